// File: rtl/psum_acc_pkg.sv
// Shared types and constants for the partial-sum accumulator.
package psum_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } psum_acc_state_t;

    localparam int PSUM_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;

    // Signed saturation limits at the default accumulator width.
    localparam logic signed [ACC_W_DEF-1:0] ACC_SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/psum_acc_lane.sv
// One accumulator lane: sign-extend the psum, shift it into place, then load or add.
// With PSUM_ACC_SAT_EN defined the shifted term and the add both saturate and
// sat_hit reports that this beat clipped.
module psum_acc_lane
    import psum_acc_pkg::*;
#(
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int SHIFT_W = 4
) (
    input  logic signed [PSUM_W-1:0] psum_in,
    input  logic        [SHIFT_W-1:0] shift_in,
    input  logic                      load_in,
    input  logic signed [ACC_W-1:0]   acc_in,
`ifdef PSUM_ACC_SAT_EN
    output logic                      sat_hit,
`endif
    output logic signed [ACC_W-1:0]   acc_next
);

`ifdef PSUM_ACC_SAT_EN
    // Wide enough to hold any psum shifted by the largest shift code without loss.
    localparam int WIDE_W = ACC_W + (1 << SHIFT_W) + 1;

    localparam logic signed [ACC_W-1:0]  LIM_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  LIM_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [WIDE_W-1:0] WIDE_MAX = WIDE_W'(LIM_MAX);
    localparam logic signed [WIDE_W-1:0] WIDE_MIN = WIDE_W'(LIM_MIN);

    function automatic logic signed [ACC_W-1:0] sat_term(input logic signed [WIDE_W-1:0] v);
        if (v > WIDE_MAX)      return LIM_MAX;
        else if (v < WIDE_MIN) return LIM_MIN;
        else                   return v[ACC_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W:0] s);
        if (s[ACC_W] == s[ACC_W-1]) return s[ACC_W-1:0];
        else if (s[ACC_W])          return LIM_MIN;
        else                        return LIM_MAX;
    endfunction

    logic signed [WIDE_W-1:0] wide_term;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W:0]    sum;
    logic                     term_ov;
    logic                     sum_ov;

    // Saturating shift and add.
    always_comb begin
        wide_term = '0;
        if (32'(shift_in) < ACC_W)
            wide_term = WIDE_W'(psum_in) <<< shift_in;
        term     = sat_term(wide_term);
        term_ov  = (wide_term > WIDE_MAX) || (wide_term < WIDE_MIN);
        sum      = {acc_in[ACC_W-1], acc_in} + {term[ACC_W-1], term};
        sum_ov   = (sum[ACC_W] != sum[ACC_W-1]);
        acc_next = load_in ? term : sat_add(sum);
        sat_hit  = term_ov || (!load_in && sum_ov);
    end
`else
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] term;

    // Wrapping shift and add; the term is truncated to ACC_W after the shift.
    always_comb begin
        ext  = {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
        term = '0;
        if (32'(shift_in) < ACC_W)
            term = ext <<< shift_in;
        acc_next = load_in ? term : acc_in + term;
    end
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Multi-pass per-column partial-sum accumulator with a one-entry result register.
// Optional build macro: PSUM_ACC_SAT_EN (saturating arithmetic plus per-lane sat_flag).
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int ARRAY_SIZE = 8,
    parameter int PSUM_W     = PSUM_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int SHIFT_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         psum_valid,
    input  logic [ARRAY_SIZE*PSUM_W-1:0] psums,
    input  logic [SHIFT_W-1:0]           psum_shift,
    input  logic                         psum_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ARRAY_SIZE*ACC_W-1:0]  out_data,
`ifdef PSUM_ACC_SAT_EN
    output logic [ARRAY_SIZE-1:0]        sat_flag,
`endif
    output logic                         busy,
    output logic                         overrun,
    input  logic                         clr_overrun
);

    psum_acc_state_t               state_q, state_d;
    logic [ARRAY_SIZE*ACC_W-1:0]   acc_q, acc_d, acc_nx;
    logic [ARRAY_SIZE*ACC_W-1:0]   out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          overrun_q, overrun_d;
    logic                          load;
`ifdef PSUM_ACC_SAT_EN
    logic [ARRAY_SIZE-1:0]         sat_hit;
    logic [ARRAY_SIZE-1:0]         tile_sat_q, tile_sat_d, tile_sat_nx;
    logic [ARRAY_SIZE-1:0]         sat_flag_q, sat_flag_d;
`endif

    // The first beat of a tile loads; the accumulator is zero in IDLE anyway.
    assign load = (state_q == IDLE);

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        psum_acc_lane #(
            .PSUM_W  (PSUM_W),
            .ACC_W   (ACC_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .psum_in  (psums[i*PSUM_W +: PSUM_W]),
            .shift_in (psum_shift),
            .load_in  (load),
            .acc_in   (acc_q[i*ACC_W +: ACC_W]),
`ifdef PSUM_ACC_SAT_EN
            .sat_hit  (sat_hit[i]),
`endif
            .acc_next (acc_nx[i*ACC_W +: ACC_W])
        );
    end

    // Next-state: accumulate, retire finished tiles into the result register, track overrun.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
`ifdef PSUM_ACC_SAT_EN
        tile_sat_nx = (load ? '0 : tile_sat_q) | sat_hit;
        tile_sat_d  = tile_sat_q;
        sat_flag_d  = sat_flag_q;
`endif
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        if (clr_overrun)
            overrun_d = 1'b0;
        if (psum_valid) begin
            acc_d   = acc_nx;
            state_d = ACCUM;
`ifdef PSUM_ACC_SAT_EN
            tile_sat_d = tile_sat_nx;
`endif
            if (psum_last) begin
                state_d = IDLE;
                acc_d   = '0;
`ifdef PSUM_ACC_SAT_EN
                tile_sat_d = '0;
`endif
                // Load when the slot is empty or being drained this same cycle.
                if (!out_valid_q || out_ready) begin
                    out_data_d  = acc_nx;
                    out_valid_d = 1'b1;
`ifdef PSUM_ACC_SAT_EN
                    sat_flag_d  = tile_sat_nx;
`endif
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PSUM_ACC_SAT_EN
            tile_sat_q  <= '0;
            sat_flag_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef PSUM_ACC_SAT_EN
            tile_sat_q  <= tile_sat_d;
            sat_flag_q  <= sat_flag_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == ACCUM);
`ifdef PSUM_ACC_SAT_EN
    assign sat_flag  = sat_flag_q;
`endif

endmodule
